// File: rtl/full_subtract_pkg.sv
// full_subtract_pkg: shared constants for the registered full subtractor.
//   SUB_MAX_WIDTH       - widest supported operand
//   RST_DIFF            - reset value of the difference register (full width, sliced by users)
//   RST_BORROW_OUT      - reset value of the borrow-out register
//   RST_OUT_VALID       - reset value of the output-valid register
package full_subtract_pkg;

  localparam int unsigned SUB_MAX_WIDTH = 64;

  localparam logic [SUB_MAX_WIDTH-1:0] RST_DIFF       = '0;
  localparam logic                     RST_BORROW_OUT = 1'b0;
  localparam logic                     RST_OUT_VALID  = 1'b0;

endpackage : full_subtract_pkg

// File: rtl/fs_cell.sv
// fs_cell: one-bit combinational full subtractor, d = a - b - bin.
//   d    - difference bit
//   bout - borrow to the next more-significant cell
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow from the less-significant cell
module fs_cell
  import full_subtract_pkg::*;
(
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fs_cell

// File: rtl/full_subtract.sv
// full_subtract: registered WIDTH-bit full subtractor, {borrowOut, diff} = a - b - borrowIn.
// Result appears one cycle after inValid; outputs hold between valid inputs.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset (wins over inValid)
//   inValid   - qualifies a, b, borrowIn this cycle
//   a, b      - unsigned minuend / subtrahend
//   borrowIn  - borrow from the less-significant stage
//   diff      - registered difference
//   borrowOut - registered borrow to the more-significant stage
//   outValid  - registered copy of inValid
module full_subtract
  import full_subtract_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             outValid
);

  // Reject unsupported widths at elaboration.
  if (WIDTH == 0 || WIDTH > SUB_MAX_WIDTH) begin : g_width_check
    $error("full_subtract: WIDTH=%0d outside 1..%0d", WIDTH, SUB_MAX_WIDTH);
  end

  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_out_valid;

  assign w_br[0] = borrowIn;

  // Ripple borrow chain, LSB first.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fs_cell u_cell (
      .d    (w_diff[gi]),
      .bout (w_br[gi+1]),
      .a    (a[gi]),
      .b    (b[gi]),
      .bin  (w_br[gi])
    );
  end

  // Result registers load only on valid input; valid is a plain one-cycle delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff       <= RST_DIFF[WIDTH-1:0];
      r_borrow_out <= RST_BORROW_OUT;
      r_out_valid  <= RST_OUT_VALID;
    end else begin
      r_out_valid <= inValid;
      if (inValid) begin
        r_diff       <= w_diff;
        r_borrow_out <= w_br[WIDTH];
      end
    end
  end

  assign diff      = r_diff;
  assign borrowOut = r_borrow_out;
  assign outValid  = r_out_valid;

endmodule : full_subtract

// File: tb/tb_full_subtract.sv
// tb_full_subtract: scoreboard bench for full_subtract at WIDTH=1, 8, 13 plus a
// two-instance 16-bit chain built from WIDTH=8 stages.
module tb_full_subtract;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       v1 = 1'b0, bi1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, d1;
  logic       bo1, ov1;
  // WIDTH=8 instance
  logic       v8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       bo8, ov8;
  // WIDTH=13 instance
  logic        v13 = 1'b0, bi13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0, d13;
  logic        bo13, ov13;
  // 16-bit chain: low and high WIDTH=8 stages
  logic       vlo = 1'b0, vhi = 1'b0;
  logic [7:0] alo = '0, blo = '0, ahi = '0, bhi = '0, dlo, dhi;
  logic       bolo, bohi, ovlo, ovhi;

  full_subtract #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .inValid(v1), .a(a1), .b(b1), .borrowIn(bi1),
    .diff(d1), .borrowOut(bo1), .outValid(ov1));
  full_subtract #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .inValid(v8), .a(a8), .b(b8), .borrowIn(bi8),
    .diff(d8), .borrowOut(bo8), .outValid(ov8));
  full_subtract #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst(rst), .inValid(v13), .a(a13), .b(b13), .borrowIn(bi13),
    .diff(d13), .borrowOut(bo13), .outValid(ov13));
  full_subtract #(.WIDTH(8)) u_lo (
    .clk(clk), .rst(rst), .inValid(vlo), .a(alo), .b(blo), .borrowIn(1'b0),
    .diff(dlo), .borrowOut(bolo), .outValid(ovlo));
  full_subtract #(.WIDTH(8)) u_hi (
    .clk(clk), .rst(rst), .inValid(vhi), .a(ahi), .b(bhi), .borrowIn(bolo),
    .diff(dhi), .borrowOut(bohi), .outValid(ovhi));

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: low (w+1) bits of the wide subtraction give {borrow, diff}.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic bi, input int unsigned w);
    logic [64:0] r;
    r = {1'b0, a} - {1'b0, b} - 65'(bi);
    return r & ((65'd1 << (w + 1)) - 65'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push at the sampling edge, pop/compare on the following negedge.
  logic [64:0] q1[$], q8[$], q13[$];
  logic [64:0] h1 = '0, h8 = '0, h13 = '0;
  logic [64:0] e;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      h1 = '0; h8 = '0; h13 = '0;
    end else begin
      if (v1)  q1.push_back(model(64'(a1), 64'(b1), bi1, 1));
      if (v8)  q8.push_back(model(64'(a8), 64'(b8), bi8, 8));
      if (v13) q13.push_back(model(64'(a13), 64'(b13), bi13, 13));
    end
    @(negedge clk);
    chk("w1_valid", 65'(ov1), 65'(q1.size() != 0));
    if (q1.size() != 0) begin e = q1.pop_front(); h1 = e; end
    chk("w1_result", 65'({bo1, d1}), h1);
    chk("w8_valid", 65'(ov8), 65'(q8.size() != 0));
    if (q8.size() != 0) begin e = q8.pop_front(); h8 = e; end
    chk("w8_result", 65'({bo8, d8}), h8);
    chk("w13_valid", 65'(ov13), 65'(q13.size() != 0));
    if (q13.size() != 0) begin e = q13.pop_front(); h13 = e; end
    chk("w13_result", 65'({bo13, d13}), h13);
  end

  // WIDTH=1 truth table indexed by {a,b,borrowIn}, entries {borrowOut,diff}.
  logic [1:0]  tt  [8];
  // WIDTH=8 vectors: {a, b, borrowIn, {borrowOut,diff}}.
  logic [25:0] vec [5];

  initial begin
    tt  = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    vec = '{{8'h00, 8'h01, 1'b0, 9'h1FF},
            {8'h80, 8'h7F, 1'b1, 9'h000},
            {8'h55, 8'h55, 1'b1, 9'h1FF},
            {8'h00, 8'hFF, 1'b1, 9'h100},
            {8'hFF, 8'h00, 1'b0, 9'h0FF}};

    tick(); tick();
    rst = 1'b0;
    chk("rst_w1",  65'({ov1, bo1, d1}), 65'(0));
    chk("rst_w8",  65'({ov8, bo8, d8}), 65'(0));
    chk("rst_w13", 65'({ov13, bo13, d13}), 65'(0));

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      tick();
      v1 = 1'b1;
      {a1, b1, bi1} = 3'(i);
      tick();
      v1 = 1'b0;
      chk($sformatf("w1_tt%0d", i), 65'({ov1, bo1, d1}), 65'({1'b1, tt[i]}));
    end

    // WIDTH=8 directed boundaries
    for (int i = 0; i < 5; i++) begin
      tick();
      v8 = 1'b1;
      {a8, b8, bi8} = vec[i][25:9];
      tick();
      v8 = 1'b0;
      chk($sformatf("w8_vec%0d", i), 65'({ov8, bo8, d8}), 65'({1'b1, vec[i][8:0]}));
    end

    // Hold: inputs toggle while inValid stays low
    tick();
    v8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; bi8 = 1'b1;
    tick();
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom()); b8 = 8'($urandom()); bi8 = 1'($urandom());
      tick();
      chk("w8_hold", 65'({ov8, bo8, d8}), 65'({1'b0, 9'h000}));
    end

    // Reset in the same cycle as a valid input
    tick();
    v8 = 1'b1; a8 = 8'h55; b8 = 8'h55; bi8 = 1'b1;
    tick();
    chk("w8_pre_rst", 65'({ov8, bo8, d8}), 65'({1'b1, 9'h1FF}));
    a8 = 8'h01; b8 = 8'h00; bi8 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; v8 = 1'b0;
    chk("w8_rst_valid", 65'({ov8, bo8, d8}), 65'(0));

    // Reset mid-stream
    tick();
    v8 = 1'b1; a8 = 8'd9; b8 = 8'd3; bi8 = 1'b0;
    tick();
    a8 = 8'd10; b8 = 8'd1;
    chk("w8_stream0", 65'({ov8, bo8, d8}), 65'({1'b1, 9'h006}));
    tick();
    a8 = 8'd2; rst = 1'b1;
    chk("w8_stream1", 65'({ov8, bo8, d8}), 65'({1'b1, 9'h009}));
    tick();
    rst = 1'b0; v8 = 1'b0;
    chk("w8_rst_mid", 65'({ov8, bo8, d8}), 65'(0));
    tick();
    chk("w8_rst_hold", 65'({ov8, bo8, d8}), 65'(0));

    // 16-bit chain: 0x0100 - 0x0001, high stage one cycle behind the low stage
    vlo = 1'b1; alo = 8'h00; blo = 8'h01;
    tick();
    vlo = 1'b0;
    vhi = 1'b1; ahi = 8'h01; bhi = 8'h00;
    chk("chain_lo", 65'({ovlo, bolo, dlo}), 65'({1'b1, 1'b1, 8'hFF}));
    tick();
    vhi = 1'b0;
    chk("chain_hi", 65'({ovhi, bohi, dhi}), 65'({1'b1, 1'b0, 8'h00}));
    chk("chain_16", 65'({dhi, dlo}), 65'(16'h00FF));

    // Random traffic with occasional reset
    for (int i = 0; i < 10000; i++) begin
      tick();
      rst  = ($urandom_range(0, 499) == 0);
      v1   = 1'($urandom()); a1  = 1'($urandom()); b1  = 1'($urandom()); bi1  = 1'($urandom());
      v8   = 1'($urandom()); a8  = 8'($urandom()); b8  = 8'($urandom()); bi8  = 1'($urandom());
      v13  = 1'($urandom()); a13 = 13'($urandom()); b13 = 13'($urandom()); bi13 = 1'($urandom());
    end
    tick();
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0; v13 = 1'b0;
    tick(); tick();
    chk("q_drained", 65'(q1.size() + q8.size() + q13.size()), 65'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_full_subtract
